// File: rtl/mskaes_input_sharer_pkg.sv
// Shared definitions for the masked AES-128 input sharer.
// Holds the FSM state encoding, the randomness budget helpers (NRND, NBEATS)
// and the share-index helpers that fix where each share and each random bit
// lives in the flattened buses.
package mskaes_input_sharer_pkg;

    // Width of one AES block (plaintext or key)
    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    // Random bits needed per encoding: (d-1) fresh masks for plaintext and key
    function automatic int nrnd(input int d);
        return 32'sd256 * (d - 32'sd1);
    endfunction

    // Number of PRNG beats needed to fill the pool
    function automatic int nbeats(input int d, input int rnd_w);
        return nrnd(d) / rnd_w;
    endfunction

    // Position of share j of bit i in a d-share bus
    function automatic int sh_idx(input int d, input int i, input int j);
        return d * i + j;
    endfunction

    // Pool bit used as mask j of plaintext bit i
    function automatic int rp_idx(input int i, input int j);
        return (j - 32'sd1) * BLK_W + i;
    endfunction

    // Pool bit used as mask j of key bit i (key masks follow all plaintext masks)
    function automatic int rk_idx(input int d, input int i, input int j);
        return BLK_W * (d - 32'sd1) + (j - 32'sd1) * BLK_W + i;
    endfunction

endpackage

// File: rtl/mskaes_input_sharer_rnd_pool.sv
// Beat-indexed randomness buffer for the input sharer.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   i_clr       - synchronous clear of pool and beat counter
//   i_wr_en     - store i_beat at the current beat slot and advance
//   i_beat      - PRNG beat
//   o_pool      - full NRND-bit pool, beat k at [k*RND_W +: RND_W]
//   o_last      - the next write fills the final slot
//   o_full      - every slot has been written
module mskaes_input_sharer_rnd_pool #(
    parameter int NRND   = 256,
    parameter int RND_W  = 32,
    parameter int NBEATS = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [RND_W-1:0]  i_beat,
    output logic [NRND-1:0]   o_pool,
    output logic              o_last,
    output logic              o_full
);

    logic [NRND-1:0]  r_pool;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full = (r_cnt == CNT_W'(NBEATS));
    assign o_last = (r_cnt == CNT_W'(NBEATS - 1));
    assign o_full = w_full;
    assign o_pool = r_pool;

    // Pool fill: one beat per enabled cycle, counter saturates at NBEATS (no wrap)
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_pool <= {NRND{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
        end else if (i_wr_en && !w_full) begin
            for (int b = 0; b < NBEATS; b++) begin
                if (r_cnt == CNT_W'(b)) begin
                    r_pool[b*RND_W +: RND_W] <= i_beat;
                end
            end
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mskaes_input_sharer.sv
// Masked AES-128 input sharer: latches an unmasked plaintext/key pair, draws
// 256*(d-1) fresh random bits from the PRNG one beat per cycle, and presents
// d-share encodings to the masked core. Everything secret is wiped on handoff.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   in_valid/in_ready          - plaintext/key handshake (accepted in IDLE)
//   umsk_plaintext, umsk_key   - unmasked block and key
//   rnd_in/rnd_valid/rnd_ready - PRNG beat stream (consumed only in FILL)
//   out_valid/out_ready        - share handoff to the core
//   sh_plaintext, sh_key       - d-share buses, shares of bit i at [d*i +: d]
module mskaes_input_sharer
    import mskaes_input_sharer_pkg::*;
#(
    parameter int d     = 2,
    parameter int RND_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLK_W-1:0]     umsk_plaintext,
    input  logic [BLK_W-1:0]     umsk_key,
    input  logic [RND_W-1:0]     rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLK_W*d-1:0]   sh_plaintext,
    output logic [BLK_W*d-1:0]   sh_key
);

    localparam int NRND   = nrnd(d);
    localparam int NBEATS = nbeats(d, RND_W);
    localparam int CNT_W  = $clog2(NBEATS) + 1;

    if (d < 2) begin : g_bad_d
        $error("mskaes_input_sharer: d must be >= 2");
    end
    if ((NRND % RND_W) != 0) begin : g_bad_rnd_w
        $error("mskaes_input_sharer: RND_W must divide 256*(d-1)");
    end

    state_e             r_state;
    logic [BLK_W-1:0]   r_pt;
    logic [BLK_W-1:0]   r_key;

    logic [NRND-1:0]    w_pool;
    logic               w_last;
    logic               w_full;
    logic               w_accept;
    logic               w_handoff;
    logic               w_beat_take;
    logic               w_pool_clr;
    logic [BLK_W*d-1:0] w_sh_p;
    logic [BLK_W*d-1:0] w_sh_k;

    assign w_accept    = (r_state == ST_IDLE) && in_valid;
    assign w_handoff   = (r_state == ST_PRESENT) && out_ready;
    assign w_beat_take = (r_state == ST_FILL) && rnd_valid && !w_full;
    // Counter restarts on accept; pool is wiped on handoff so no mask is reused
    assign w_pool_clr  = w_accept || w_handoff;

    // Handshake outputs decode straight from the state; reset masks them at once
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign rnd_ready = (r_state == ST_FILL) && !w_full && !rst;
    assign out_valid = (r_state == ST_PRESENT) && !rst;

    mskaes_input_sharer_rnd_pool #(
        .NRND   (NRND),
        .RND_W  (RND_W),
        .NBEATS (NBEATS),
        .CNT_W  (CNT_W)
    ) u_pool (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_pool_clr),
        .i_wr_en (w_beat_take),
        .i_beat  (rnd_in),
        .o_pool  (w_pool),
        .o_last  (w_last),
        .o_full  (w_full)
    );

    // Control FSM plus the latched plaintext/key, both cleared on handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pt    <= {BLK_W{1'b0}};
            r_key   <= {BLK_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_pt    <= umsk_plaintext;
                        r_key   <= umsk_key;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_beat_take && w_last) begin
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        r_pt    <= {BLK_W{1'b0}};
                        r_key   <= {BLK_W{1'b0}};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pt    <= {BLK_W{1'b0}};
                    r_key   <= {BLK_W{1'b0}};
                end
            endcase
        end
    end

    // Share encoder: shares 1..d-1 are raw masks, share 0 folds them into the bit
    always_comb begin
        logic acc_p;
        logic acc_k;
        w_sh_p = {(BLK_W*d){1'b0}};
        w_sh_k = {(BLK_W*d){1'b0}};
        acc_p  = 1'b0;
        acc_k  = 1'b0;
        for (int i = 0; i < BLK_W; i++) begin
            acc_p = r_pt[i];
            acc_k = r_key[i];
            for (int j = 1; j < d; j++) begin
                w_sh_p[sh_idx(d, i, j)] = w_pool[rp_idx(i, j)];
                w_sh_k[sh_idx(d, i, j)] = w_pool[rk_idx(d, i, j)];
                acc_p = acc_p ^ w_pool[rp_idx(i, j)];
                acc_k = acc_k ^ w_pool[rk_idx(d, i, j)];
            end
            w_sh_p[sh_idx(d, i, 0)] = acc_p;
            w_sh_k[sh_idx(d, i, 0)] = acc_k;
        end
    end

    // Shares are exposed only while presenting, never half-filled encodings
    assign sh_plaintext = (r_state == ST_PRESENT) ? w_sh_p : {(BLK_W*d){1'b0}};
    assign sh_key       = (r_state == ST_PRESENT) ? w_sh_k : {(BLK_W*d){1'b0}};

endmodule
